// File: rtl/proc_mem_bridge.sv
// Processor-to-memory bridge: queues requests in a small FIFO and issues them one at a time
// to a fixed-latency synchronous memory, returning read data with a one-cycle response pulse.
module proc_mem_bridge #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned WDATA_W = 16,
  parameter int unsigned RDATA_W = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cs,
  input  logic               read_req,
  input  logic               write_req,
  input  logic [ADDR_W-1:0]  addrout,
  input  logic [WDATA_W-1:0] datatomem,
  output logic               req_ready,
  output logic               mem_resp,
  output logic [RDATA_W-1:0] datafrommem,
  output logic               err_pulse,
  output logic               busy,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  input  logic [RDATA_W-1:0] mem_rdata
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  localparam logic [PtrW:0]   Full    = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] Lat     = CntW'(MEM_LAT);
  localparam logic [CntW-1:0] LatOne  = CntW'(1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic               fifo_we    [DEPTH];
  logic [ADDR_W-1:0]  fifo_addr  [DEPTH];
  logic [WDATA_W-1:0] fifo_wdata [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic push, pop, last, illegal, has_head;

  assign req_ready = (count_q != Full);
  assign push      = cs & (read_req ^ write_req) & req_ready;
  assign illegal   = cs & read_req & write_req;
  assign has_head  = (count_q != '0);
  assign last      = (state_q == StWait) && (cnt_q == LatOne);
  // A new head may issue from IDLE or on the very edge the current transaction completes.
  assign pop       = has_head && ((state_q == StIdle) || last);
  assign busy      = has_head || (state_q == StWait);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (pop) begin
      state_d = StWait;
      cnt_d   = Lat;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q - LatOne;
      if (last) begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr_q]    <= write_req;
      fifo_addr[wr_ptr_q]  <= addrout;
      fifo_wdata[wr_ptr_q] <= datatomem;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_resp    <= 1'b0;
      datafrommem <= '0;
      err_pulse   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      mem_en    <= pop;
      mem_resp  <= last;
      err_pulse <= illegal;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PtrOne;
        mem_we    <= fifo_we[rd_ptr_q];
        mem_addr  <= fifo_addr[rd_ptr_q];
        mem_wdata <= fifo_wdata[rd_ptr_q];
      end
      // mem_we still describes the completing transaction here; a same-edge reissue
      // only overwrites it after this sample.
      if (last && !mem_we) begin
        datafrommem <= mem_rdata;
      end
    end
  end

endmodule
